// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract accumulator.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  localparam logic [3:0] SAT_POS = 4'b0111;
  localparam logic [3:0] SAT_NEG = 4'b1000;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/adder_subtractor.sv
// Ripple-style adder/subtractor: S = A + B when M=0, A - B (two's complement) when M=1.
module adder_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_total;

  assign w_b_eff = B ^ {WIDTH{M}};
  assign w_total = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, M};
  assign S       = w_total[WIDTH-1:0];
  assign C       = w_total[WIDTH];
  // Overflow: both effective operands share a sign that the result does not.
  assign V       = (A[WIDTH-1] == w_b_eff[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);

endmodule

// File: rtl/addsub_accumulator.sv
// Handshaked accumulator around adder_subtractor (IDLE -> EXEC -> RESP).
// Define ADDSUB_SATURATE_EN to clamp ADD/SUB overflow instead of wrapping.
module addsub_accumulator
  import addsub_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = 4'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic [3:0]       out_flags,
  output logic             ovf_sticky
);

  state_t                  r_state, w_state_next;
  op_t                     r_op;
  logic signed [WIDTH-1:0] r_b;
  logic [WIDTH-1:0]        r_acc;
  logic [3:0]              r_flags;
  logic                    r_sticky;

  logic [WIDTH-1:0]        w_sum, w_acc_next;
  logic                    w_carry, w_ovf, w_sub, w_c_next, w_v_next;
  logic [3:0]              w_flags_next;

`ifdef ADDSUB_SATURATE_EN
  function automatic logic [WIDTH-1:0] sat_result(input logic signed [WIDTH-1:0] s_wrapped,
                                                  input logic ovf);
    if (!ovf) return s_wrapped;
    // A wrapped result with the sign bit set came from a positive overflow.
    return s_wrapped[WIDTH-1] ? SAT_POS : SAT_NEG;
  endfunction
`endif

  assign w_sub = (r_op == OP_SUB);

  adder_subtractor #(.WIDTH(WIDTH)) u_addsub (
    .A (r_acc),
    .B (r_b),
    .M (w_sub),
    .S (w_sum),
    .C (w_carry),
    .V (w_ovf)
  );

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign out_valid  = (r_state == S_RESP);
  assign out_acc    = r_acc;
  assign out_flags  = r_flags;
  assign ovf_sticky = r_sticky;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid && in_ready) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_acc_next = w_sum;
    w_c_next   = 1'b0;
    w_v_next   = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
`ifdef ADDSUB_SATURATE_EN
        w_acc_next = sat_result(w_sum, w_ovf);
`else
        w_acc_next = w_sum;
`endif
        w_c_next = w_carry;
        w_v_next = w_ovf;
      end
      OP_LOAD:  w_acc_next = r_b;
      OP_CLEAR: w_acc_next = '0;
      default:  w_acc_next = w_sum;
    endcase
    w_flags_next         = 4'b0000;
    w_flags_next[FLAG_N] = w_acc_next[WIDTH-1];
    w_flags_next[FLAG_Z] = (w_acc_next == '0);
    w_flags_next[FLAG_C] = w_c_next;
    w_flags_next[FLAG_V] = w_v_next;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Command capture in IDLE; result capture at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= ACC_INIT;
      r_flags  <= 4'b0000;
      r_sticky <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_acc    <= w_acc_next;
      r_flags  <= w_flags_next;
      r_sticky <= (r_op == OP_CLEAR) ? 1'b0 : (r_sticky | w_v_next);
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r_op <= op_t'(in_op);
      r_b  <= in_b;
    end
  end

endmodule

// File: tb/tb_addsub_accumulator.sv
// Randomized self-checking bench for addsub_accumulator against an arithmetic reference model.
module tb_addsub_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_acc;
  logic [3:0] out_flags;
  logic       ovf_sticky;

  int total = 0;
  int bad   = 0;

  int m_acc    = 0;
  int m_flags  = 0;
  int m_sticky = 0;

  addsub_accumulator #(.WIDTH(4), .ACC_INIT(4'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_flags  (out_flags),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_signed4(input int v);
    return (v > 7) ? v - 16 : v;
  endfunction

  // Reference: plain integer arithmetic on the architectural accumulator.
  function automatic void model_cmd(input logic [1:0] op, input logic [3:0] b);
    int bi, sa, sb, ss, r, c, v;
    bi = int'(b);
    sa = to_signed4(m_acc);
    sb = to_signed4(bi);
    c  = 0;
    v  = 0;
    ss = 0;
    r  = 0;
    case (op)
      2'b00: begin
        ss = sa + sb;
        r  = (m_acc + bi) % 16;
        c  = (m_acc + bi > 15) ? 1 : 0;
        v  = (ss > 7 || ss < -8) ? 1 : 0;
      end
      2'b01: begin
        ss = sa - sb;
        r  = (m_acc - bi + 16) % 16;
        c  = (m_acc >= bi) ? 1 : 0;
        v  = (ss > 7 || ss < -8) ? 1 : 0;
      end
      2'b10: r = bi;
      default: begin
        r = 0;
        m_sticky = 0;
      end
    endcase
`ifdef ADDSUB_SATURATE_EN
    if (v == 1) r = (ss > 7) ? 7 : 8;
`endif
    if (v == 1) m_sticky = 1;
    m_acc   = r;
    m_flags = ((r >= 8) ? 8 : 0) + ((r == 0) ? 4 : 0) + c * 2 + v;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_in_ready", in_ready, 1'b1);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_acc"}, out_acc, m_acc);
    chk({tag, "_flags"}, out_flags, m_flags);
    chk({tag, "_sticky"}, ovf_sticky, m_sticky);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] b, input int hold);
    wait_idle();
    in_valid  = 1'b1;
    in_op     = op;
    in_b      = b;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_cmd(op, b);
    chk("exec_out_valid", out_valid, 1'b0);
    chk("exec_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    check_result("resp");
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_result("hold");
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_b      = 4'h0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_acc", out_acc, 4'h0);
    chk("post_rst_flags", out_flags, 4'h0);
    chk("post_rst_sticky", ovf_sticky, 1'b0);

    do_cmd(2'b00, 4'd5, 0);
    chk("t1_acc_const", out_acc, 4'd5);
    do_cmd(2'b00, 4'd3, 0);
`ifdef ADDSUB_SATURATE_EN
    chk("t2_acc_const", out_acc, 4'b0111);
`else
    chk("t2_acc_const", out_acc, 4'b1000);
`endif
    chk("t2_sticky_const", ovf_sticky, 1'b1);
    do_cmd(2'b10, 4'd3, 0);
    do_cmd(2'b01, 4'd5, 0);
    chk("t3_sub_acc_const", out_acc, 4'b1110);
    chk("t3_sub_flags_const", out_flags, 4'b1000);
    do_cmd(2'b10, 4'd3, 0);
    do_cmd(2'b01, 4'd3, 0);
    chk("t3_zero_flags_const", out_flags, 4'b0110);

    // Backpressure with a second command held on in_valid throughout.
    wait_idle();
    in_valid = 1'b1; in_op = 2'b00; in_b = 4'd1; out_ready = 1'b0;
    @(posedge clk); #1;
    model_cmd(2'b00, 4'd1);
    in_op = 2'b00; in_b = 4'd4;
    @(posedge clk); #1;
    check_result("bp_resp");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_result("bp_hold");
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_out_valid", out_valid, 1'b0);
    chk("bp_idle_in_ready", in_ready, 1'b1);
    model_cmd(2'b00, 4'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_exec", in_ready, 1'b0);
    @(posedge clk); #1;
    check_result("bp_second");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Overflow to set sticky, then reset in EXEC aborts the command.
    do_cmd(2'b10, 4'd7, 0);
    do_cmd(2'b00, 4'd7, 1);
    wait_idle();
    in_valid = 1'b1; in_op = 2'b00; in_b = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    m_acc = 0; m_flags = 0; m_sticky = 0;
    chk("abort_acc", out_acc, 4'h0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_sticky", ovf_sticky, 1'b0);
    @(posedge clk); #1;
    chk("abort_no_result", out_valid, 1'b0);

    // Sticky set, then CLEAR.
    do_cmd(2'b10, 4'd8, 0);
    do_cmd(2'b01, 4'd1, 0);
    chk("t6_sticky_set", ovf_sticky, 1'b1);
    do_cmd(2'b11, 4'd9, 2);
    chk("t6_clear_acc", out_acc, 4'h0);
    chk("t6_clear_sticky", ovf_sticky, 1'b0);

    for (int k = 0; k < 200; k++) begin
      logic [1:0] op;
      int r;
      r  = int'($urandom_range(0, 9));
      op = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      do_cmd(op, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
